rounding_unit_sticky_pipe: RTL and testbench
============================================

# rounding_unit_sticky_pipe

Registered, parametrised guard/sticky extraction stage for the rounding unit. It takes a normalized fraction and a divider/sqrt remainder and produces one registered result per operation: guard bit, sticky bit, beat count and a pass-through tag. Four selectable modes cover add/sub/mul, div/sqrt, float-to-int, and multi-beat remainder accumulation for iterative dividers that deliver the remainder in chunks. It sits between normalization and the round-increment logic, with valid/ready flow control on both sides.

## Interface
- FRAC_WIDTH, 49: normalized fraction width, [xx.xxx…] format.
- REM_WIDTH, 27: remainder width per beat.
- ADDMUL_BITS, 22: number of fraction LSBs ORed into sticky in ADDMUL mode. Range 1..FRAC_WIDTH-1.
- F2I_BITS, 15: number of fraction LSBs ORed into sticky in F2I mode. Range 1..FRAC_WIDTH-1.
- TAG_WIDTH, 8: pass-through tag width.
- BEAT_CNT_WIDTH, 4: width of the beat counter.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort; clears the accumulator and the output register.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_mode  in  2  sticky_mode_t.
- in_last  in  1  final beat; used only in REM_ACC mode, ignored otherwise.
- in_fraction  in  FRAC_WIDTH  normalized fraction.
- in_remainder  in  REM_WIDTH  remainder chunk.
- in_tag  in  TAG_WIDTH  operation tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_guard  out  1  guard bit.
- out_sticky  out  1  sticky bit.
- out_beats  out  BEAT_CNT_WIDTH  number of beats merged, saturating.
- out_tag  out  TAG_WIDTH  tag of the final beat.

## Operation
Per-mode results for the current beat:
- ADDMUL (0): sticky = |frac[ADDMUL_BITS-1:0]; guard = frac[ADDMUL_BITS].
- REM (1): sticky = |remainder; guard = frac[0].
- F2I (2): sticky = |frac[F2I_BITS-1:0]; guard = frac[F2I_BITS].
- REM_ACC (3): beat sticky = |remainder.
  - Beat with in_last=0: acc_sticky |= beat sticky, beat_cnt += 1 (saturates at all-ones). No output is produced.
  - Beat with in_last=1: the output is loaded with sticky = acc_sticky | beat sticky, guard = frac[0], beats = beat_cnt+1 (saturating). acc_sticky and beat_cnt then clear.

Other rules:
- Modes 0–2 always produce an output with beats = 1, and do not disturb the accumulator state.
- in_mode may change only at REM_ACC operation boundaries. A non-ACC beat arriving mid-accumulation is processed normally and leaves the accumulator untouched.
- Handshake: in_ready = !flush && (!out_valid || out_ready).
  - Once out_valid is high, all output fields are held stable until out_ready is high.
  - Non-final accumulation beats are accepted under the same in_ready rule.
- flush has priority over everything else. In the cycle it is high:
  - no beat is accepted;
  - on the next edge out_valid = 0, acc_sticky = 0, beat_cnt = 0.
- Reset (async assert, any time including mid-accumulation): out_valid = 0, out_guard = 0, out_sticky = 0, out_beats = 0, out_tag = 0, acc_sticky = 0, beat_cnt = 0.

## Timing
- Latency: 1 cycle from acceptance of a final (or single-beat) input to out_valid.
- Full throughput: one result per cycle while out_ready stays high.
- Simultaneous events:
  - Output drain and new input in the same cycle: the output register reloads in the same cycle.
  - Output stalled (out_valid && !out_ready): in_ready = 0, and the accumulator is frozen as well.
- Beat counter saturation is at 2^BEAT_CNT_WIDTH-1. Sticky accumulation remains correct past saturation.

## Structure
- Shared package rounding_unit_pkg holds:
  - typedef enum logic [1:0] sticky_mode_t {STICKY_ADDMUL, STICKY_REM, STICKY_F2I, STICKY_REM_ACC};
  - the default width constants.
- One combinational sub-module, rounding_unit_sticky_reduce: mode-muxed guard/sticky reduction, parametrised like the top. The top module holds the accumulator, the beat counter, the output register and the handshake.

## Test plan
- ADDMUL, frac = 49'h0_0000_0040_0000 (bit 22 set, bits 21:0 zero) -> guard = 1, sticky = 0, beats = 1, out_valid one cycle after acceptance.
- F2I, frac with only bit 3 set; then REM with remainder = 0 -> first result guard = 0, sticky = 1; second result sticky = 0.
- REM_ACC, remainders 0, 27'h4, 0 with last on the third beat -> a single output with sticky = 1, beats = 3; the next REM_ACC single beat of 0 gives sticky = 0, beats = 1.
- Hold out_ready low for 5 cycles with in_valid high -> in_ready = 0 and outputs stable; release -> back-to-back results with no loss or duplication, tags in order.
- Assert flush after two REM_ACC beats (one nonzero), then send a last beat of 0 -> sticky = 0, beats = 1. Flush together with in_valid -> beat not accepted.
- Assert reset_n low mid-accumulation while out_valid = 1 -> all outputs and state zero immediately. With BEAT_CNT_WIDTH = 2, send 6 accumulated beats -> out_beats = 3.

Source files
------------

// File: rtl/rounding_unit_pkg.sv
// rtl/rounding_unit_pkg.sv - shared types and default widths for the rounding unit
package rounding_unit_pkg;

  typedef enum logic [1:0] {
    STICKY_ADDMUL,
    STICKY_REM,
    STICKY_F2I,
    STICKY_REM_ACC
  } sticky_mode_t;

  localparam int DEF_FRAC_WIDTH     = 49;
  localparam int DEF_REM_WIDTH      = 27;
  localparam int DEF_ADDMUL_BITS    = 22;
  localparam int DEF_F2I_BITS       = 15;
  localparam int DEF_TAG_WIDTH      = 8;
  localparam int DEF_BEAT_CNT_WIDTH = 4;

endpackage

// File: rtl/rounding_unit_sticky_pipe_if.sv
// rtl/rounding_unit_sticky_pipe_if.sv - beat input and result output handshake bundle
interface rounding_unit_sticky_pipe_if
  import rounding_unit_pkg::*;
#(
  parameter int FRAC_WIDTH     = DEF_FRAC_WIDTH,
  parameter int REM_WIDTH      = DEF_REM_WIDTH,
  parameter int TAG_WIDTH      = DEF_TAG_WIDTH,
  parameter int BEAT_CNT_WIDTH = DEF_BEAT_CNT_WIDTH
);

  logic                      in_valid;
  logic                      in_ready;
  sticky_mode_t              in_mode;
  logic                      in_last;
  logic [FRAC_WIDTH-1:0]     in_fraction;
  logic [REM_WIDTH-1:0]      in_remainder;
  logic [TAG_WIDTH-1:0]      in_tag;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_guard;
  logic                      out_sticky;
  logic [BEAT_CNT_WIDTH-1:0] out_beats;
  logic [TAG_WIDTH-1:0]      out_tag;

  modport master (
    output in_valid, in_mode, in_last, in_fraction, in_remainder, in_tag, out_ready,
    input  in_ready, out_valid, out_guard, out_sticky, out_beats, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_last, in_fraction, in_remainder, in_tag, out_ready,
    output in_ready, out_valid, out_guard, out_sticky, out_beats, out_tag
  );

endinterface

// File: rtl/rounding_unit_sticky_reduce.sv
// rtl/rounding_unit_sticky_reduce.sv - mode-muxed guard/sticky reduction of one beat
module rounding_unit_sticky_reduce
  import rounding_unit_pkg::*;
#(
  parameter int FRAC_WIDTH  = DEF_FRAC_WIDTH,
  parameter int REM_WIDTH   = DEF_REM_WIDTH,
  parameter int ADDMUL_BITS = DEF_ADDMUL_BITS,
  parameter int F2I_BITS    = DEF_F2I_BITS
) (
  input  sticky_mode_t          mode,
  input  logic [FRAC_WIDTH-1:0] fraction,
  input  logic [REM_WIDTH-1:0]  remainder,
  output logic                  guard,
  output logic                  sticky
);

  // Fraction bits above the widest reduction window never affect the result.
  logic unused_fraction;
  assign unused_fraction = ^fraction;

  always_comb begin
    guard  = fraction[0];
    sticky = |remainder;
    unique case (mode)
      STICKY_ADDMUL: begin
        guard  = fraction[ADDMUL_BITS];
        sticky = |fraction[ADDMUL_BITS-1:0];
      end
      STICKY_F2I: begin
        guard  = fraction[F2I_BITS];
        sticky = |fraction[F2I_BITS-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rounding_unit_sticky_pipe.sv
// rtl/rounding_unit_sticky_pipe.sv - registered guard/sticky stage with remainder accumulation
module rounding_unit_sticky_pipe
  import rounding_unit_pkg::*;
#(
  parameter int FRAC_WIDTH     = DEF_FRAC_WIDTH,
  parameter int REM_WIDTH      = DEF_REM_WIDTH,
  parameter int ADDMUL_BITS    = DEF_ADDMUL_BITS,
  parameter int F2I_BITS       = DEF_F2I_BITS,
  parameter int TAG_WIDTH      = DEF_TAG_WIDTH,
  parameter int BEAT_CNT_WIDTH = DEF_BEAT_CNT_WIDTH
) (
  input logic                        clk,
  input logic                        reset_n,
  input logic                        flush,
  rounding_unit_sticky_pipe_if.slave bus
);

  logic                      beat_guard;
  logic                      beat_sticky;
  logic                      acc_sticky;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_inc;
  logic                      out_valid_q;
  logic                      out_guard_q;
  logic                      out_sticky_q;
  logic [BEAT_CNT_WIDTH-1:0] out_beats_q;
  logic [TAG_WIDTH-1:0]      out_tag_q;
  logic                      fire;
  logic                      is_acc;
  logic                      load_out;
  logic                      acc_fire;

  rounding_unit_sticky_reduce #(
    .FRAC_WIDTH (FRAC_WIDTH),
    .REM_WIDTH  (REM_WIDTH),
    .ADDMUL_BITS(ADDMUL_BITS),
    .F2I_BITS   (F2I_BITS)
  ) u_reduce (
    .mode     (bus.in_mode),
    .fraction (bus.in_fraction),
    .remainder(bus.in_remainder),
    .guard    (beat_guard),
    .sticky   (beat_sticky)
  );

  // A stalled output also freezes the accumulator, since no beat is accepted.
  assign bus.in_ready  = !flush && (!out_valid_q || bus.out_ready);
  assign fire          = bus.in_valid && bus.in_ready;
  assign is_acc        = (bus.in_mode == STICKY_REM_ACC);
  assign load_out      = fire && (!is_acc || bus.in_last);
  assign acc_fire      = fire && is_acc;
  assign beat_cnt_inc  = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_guard_q  <= 1'b0;
      out_sticky_q <= 1'b0;
      out_beats_q  <= '0;
      out_tag_q    <= '0;
      acc_sticky   <= 1'b0;
      beat_cnt     <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      out_guard_q  <= 1'b0;
      out_sticky_q <= 1'b0;
      out_beats_q  <= '0;
      out_tag_q    <= '0;
      acc_sticky   <= 1'b0;
      beat_cnt     <= '0;
    end else begin
      if (load_out) begin
        out_valid_q  <= 1'b1;
        out_guard_q  <= beat_guard;
        out_sticky_q <= is_acc ? (acc_sticky | beat_sticky) : beat_sticky;
        out_beats_q  <= is_acc ? beat_cnt_inc : BEAT_CNT_WIDTH'(1);
        out_tag_q    <= bus.in_tag;
      end else if (bus.out_ready) begin
        out_valid_q  <= 1'b0;
      end
      if (acc_fire) begin
        if (bus.in_last) begin
          acc_sticky <= 1'b0;
          beat_cnt   <= '0;
        end else begin
          acc_sticky <= acc_sticky | beat_sticky;
          beat_cnt   <= beat_cnt_inc;
        end
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_guard  = out_guard_q;
  assign bus.out_sticky = out_sticky_q;
  assign bus.out_beats  = out_beats_q;
  assign bus.out_tag    = out_tag_q;

endmodule

// File: tb/tb_rounding_unit_sticky_pipe.sv
// tb/tb_rounding_unit_sticky_pipe.sv - self-checking bench for rounding_unit_sticky_pipe
module tb_rounding_unit_sticky_pipe;
  import rounding_unit_pkg::*;

  localparam int FW   = DEF_FRAC_WIDTH;
  localparam int RW   = DEF_REM_WIDTH;
  localparam int AB   = DEF_ADDMUL_BITS;
  localparam int FB   = DEF_F2I_BITS;
  localparam int TW   = DEF_TAG_WIDTH;
  localparam int BCW  = 2;
  localparam int MAXB = (1 << BCW) - 1;

  typedef struct {
    logic          guard;
    logic          sticky;
    int            beats;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk;
  logic reset_n;
  logic flush;

  rounding_unit_sticky_pipe_if #(.FRAC_WIDTH(FW), .REM_WIDTH(RW), .TAG_WIDTH(TW),
                                 .BEAT_CNT_WIDTH(BCW)) bus ();

  rounding_unit_sticky_pipe #(.BEAT_CNT_WIDTH(BCW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (flush),
    .bus    (bus.slave)
  );

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t q[$];
  bit   m_acc   = 0;
  int   m_cnt   = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: expected result of an accepted beat from the mode rules.
  task automatic model_accept();
    longint unsigned f  = longint'(bus.in_fraction);
    bit              rs = (bus.in_remainder != 0);
    exp_t            e;
    e.tag   = bus.in_tag;
    e.beats = 1;
    e.guard = ((f & 1) != 0);
    e.sticky = rs;
    case (bus.in_mode)
      STICKY_ADDMUL: begin
        e.guard  = (((f >> AB) & 1) != 0);
        e.sticky = ((f % (64'd1 << AB)) != 0);
      end
      STICKY_F2I: begin
        e.guard  = (((f >> FB) & 1) != 0);
        e.sticky = ((f % (64'd1 << FB)) != 0);
      end
      STICKY_REM: ;
      default: begin
        m_cnt++;
        m_acc = m_acc | rs;
        if (!bus.in_last) return;
        e.sticky = m_acc;
        e.beats  = (m_cnt > MAXB) ? MAXB : m_cnt;
        m_acc = 0;
        m_cnt = 0;
      end
    endcase
    q.push_back(e);
  endtask

  initial begin : compare
    bit exp_valid;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_fields", {bus.out_guard, bus.out_sticky, bus.out_beats, bus.out_tag}, 0);
        q.delete();
        m_acc = 0;
        m_cnt = 0;
      end else begin
        exp_valid = (q.size() != 0);
        chk("out_valid", bus.out_valid, exp_valid);
        chk("in_ready", bus.in_ready, !flush && (!exp_valid || bus.out_ready));
        if (exp_valid && bus.out_valid) begin
          chk("out_guard", bus.out_guard, q[0].guard);
          chk("out_sticky", bus.out_sticky, q[0].sticky);
          chk("out_beats", bus.out_beats, q[0].beats);
          chk("out_tag", bus.out_tag, q[0].tag);
        end
        if (flush) begin
          q.delete();
          m_acc = 0;
          m_cnt = 0;
        end else begin
          if (exp_valid && bus.out_ready) void'(q.pop_front());
          if (bus.in_valid && bus.in_ready) model_accept();
        end
      end
    end
  end

  task automatic send(input sticky_mode_t m, input logic last, input logic [FW-1:0] f,
                      input logic [RW-1:0] r, input logic [TW-1:0] t);
    bit done = 0;
    bus.in_valid     = 1;
    bus.in_mode      = m;
    bus.in_last      = last;
    bus.in_fraction  = f;
    bus.in_remainder = r;
    bus.in_tag       = t;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
    end
    chk("accept_timeout", done, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
  endtask

  task automatic expect_out(input string name, input logic g, input logic s,
                            input int b, input logic [TW-1:0] t);
    chk({name, "_valid"}, bus.out_valid, 1);
    chk({name, "_guard"}, bus.out_guard, g);
    chk({name, "_sticky"}, bus.out_sticky, s);
    chk({name, "_beats"}, bus.out_beats, b);
    chk({name, "_tag"}, bus.out_tag, t);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    reset_n          = 0;
    flush            = 0;
    bus.in_valid     = 0;
    bus.in_mode      = STICKY_ADDMUL;
    bus.in_last      = 0;
    bus.in_fraction  = '0;
    bus.in_remainder = '0;
    bus.in_tag       = '0;
    bus.out_ready    = 1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1;
    @(posedge clk);
    #1;

    send(STICKY_ADDMUL, 0, 49'h0_0000_0040_0000, '0, 8'd1);
    expect_out("addmul", 1, 0, 1, 8'd1);
    send(STICKY_F2I, 0, 49'h8, '0, 8'd2);
    expect_out("f2i", 0, 1, 1, 8'd2);
    send(STICKY_REM, 0, '0, '0, 8'd3);
    expect_out("rem", 0, 0, 1, 8'd3);

    send(STICKY_REM_ACC, 0, '0, 27'h0, 8'd4);
    send(STICKY_REM_ACC, 0, '0, 27'h4, 8'd5);
    send(STICKY_REM_ACC, 1, '0, 27'h0, 8'd6);
    expect_out("acc3", 0, 1, 3, 8'd6);
    send(STICKY_REM_ACC, 1, '0, 27'h0, 8'd7);
    expect_out("acc1", 0, 0, 1, 8'd7);

    // Backpressure: result 8 held while beat 9 waits.
    @(posedge clk);
    #1;
    bus.out_ready = 0;
    send(STICKY_REM, 0, 49'h1, 27'h3, 8'd8);
    fork
      send(STICKY_REM, 0, 49'h0, 27'h0, 8'd9);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", bus.in_ready, 0);
          chk("stall_tag", bus.out_tag, 8'd8);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1;
      end
    join
    expect_out("drain9", 0, 0, 1, 8'd9);
    send(STICKY_ADDMUL, 0, 49'h3, '0, 8'd10);
    send(STICKY_F2I, 0, 49'h8000, '0, 8'd11);
    expect_out("b2b11", 1, 0, 1, 8'd11);

    send(STICKY_REM_ACC, 0, '0, 27'h5, 8'd12);
    send(STICKY_REM_ACC, 0, '0, 27'h0, 8'd13);
    flush            = 1;
    bus.in_valid     = 1;
    bus.in_mode      = STICKY_REM_ACC;
    bus.in_last      = 1;
    bus.in_remainder = 27'h5;
    bus.in_tag       = 8'd14;
    @(negedge clk);
    chk("flush_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    flush        = 0;
    bus.in_valid = 0;
    chk("flush_out_valid", bus.out_valid, 0);
    send(STICKY_REM_ACC, 1, '0, 27'h0, 8'd15);
    expect_out("post_flush", 0, 0, 1, 8'd15);

    for (int i = 0; i < 6; i++)
      send(STICKY_REM_ACC, (i == 5), '0, (i == 4) ? 27'h1 : 27'h0, TW'(16 + i));
    expect_out("saturate", 0, 1, 3, 8'd21);

    send(STICKY_REM_ACC, 0, '0, 27'h7, 8'd22);
    bus.out_ready = 0;
    send(STICKY_REM, 0, '0, 27'h0, 8'd23);
    expect_out("mid_acc_rem", 0, 0, 1, 8'd23);
    #2;
    reset_n = 0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_fields", {bus.out_guard, bus.out_sticky, bus.out_beats, bus.out_tag}, 0);
    @(posedge clk);
    #1;
    reset_n       = 1;
    bus.out_ready = 1;
    send(STICKY_REM_ACC, 1, 49'h1, 27'h0, 8'd24);
    expect_out("post_reset", 1, 0, 1, 8'd24);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
